// File: rtl/bf16_addsub_pkg.sv
// Shared types, field positions and result packing for the BF16/INT8 add/sub sequencer.
// Build option: BF16_ADDSUB_SAT_EN packs exponent overflow as signed infinity.
package bf16_addsub_pkg;

   localparam int MANT_W    = 10;
   localparam int MAX_SHIFT = 10;
   localparam int SHIFT_W   = 4;
   localparam int ER_W      = 9;

   localparam int SIGN_BIT  = 15;
   localparam int EXP_MSB   = 14;
   localparam int EXP_LSB   = 7;
   localparam int FRAC_MSB  = 6;
   localparam int FRAC_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [15:0] result;
      logic        ovf;
   } pack_t;

   // A zero magnitude is never reported as an overflow, whatever er holds.
   function automatic pack_t pack_result(input logic             sign,
                                         input logic [ER_W-1:0]   er,
                                         input logic [MANT_W-1:0] r);
      pack_t p;
      p.ovf    = (r != '0) && (er >= ER_W'(255));
      p.result = '0;
      if (r != '0) begin
`ifdef BF16_ADDSUB_SAT_EN
         if (p.ovf) p.result = {sign, 8'hFF, 7'h00};
         else       p.result = {sign, er[7:0], r[MANT_W-2:2]};
`else
         p.result = {sign, er[7:0], r[MANT_W-2:2]};
`endif
      end
      return p;
   endfunction

endpackage

// File: rtl/bf16_addsub_sequencer_if.sv
// Request/response bundle between operand issue, the sequencer and result writeback.
interface bf16_addsub_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_sub;
   logic        in_int8;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_ovf;
   logic        busy;

   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_int8, out_ready,
      output in_ready, out_valid, out_result, out_ovf, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_sub, in_int8, out_ready,
      input  in_ready, out_valid, out_result, out_ovf, busy
   );
endinterface

// File: rtl/bf16_addsub_sequencer_norm_step.sv
// One left-shift normalization step; done when the carry bit is set, r is zero or er is exhausted.
module bf16_norm_step
   import bf16_addsub_pkg::*;
(
   input  logic [MANT_W-1:0] r_i,
   input  logic [ER_W-1:0]   er_i,
   output logic [MANT_W-1:0] r_o,
   output logic [ER_W-1:0]   er_o,
   output logic              done_o
);
   assign done_o = r_i[MANT_W-1] | (r_i == '0) | (er_i == '0);
   assign r_o    = {r_i[MANT_W-2:0], 1'b0};
   assign er_o   = er_i - ER_W'(1);
endmodule

// File: rtl/bf16_addsub_sequencer.sv
// Sequenced BF16/INT8 add/sub: serial alignment, one add, serial normalization.
// Build option: BF16_ADDSUB_SAT_EN (see bf16_addsub_pkg::pack_result).
//   state | meaning
//   IDLE  | ready for a new operation
//   ALIGN | shift smaller-exponent mantissa right one bit per cycle
//   ADD   | mantissa add/sub (or INT8 add/sub)
//   NORM  | shift result left one bit per cycle, pack on exit
//   DONE  | result held until accepted
module bf16_addsub_sequencer
   import bf16_addsub_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   bf16_addsub_sequencer_if.slave bus
);

   state_t              state_q, state_d;
   logic [MANT_W-1:0]   ma_q, ma_d, mb_q, mb_d, r_q, r_d;
   logic [ER_W-1:0]     er_q, er_d;
   logic [SHIFT_W-1:0]  d_q, d_d;
   logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_r_q, sign_r_d;
   logic                shift_b_q, shift_b_d, int8_q, int8_d, sub_q, sub_d;
   logic [7:0]          a8_q, a8_d, b8_q, b8_d, s8_q, s8_d;
   logic                v8_q, v8_d;
   logic [15:0]         out_result_q, out_result_d;
   logic                out_ovf_q, out_ovf_d;
   logic                in_ready_q, out_valid_q, busy_q;

   logic [7:0]          ea, eb, ediff;
   logic [SHIFT_W-1:0]  d_init;
   logic [MANT_W-1:0]   r_add, norm_r;
   logic [ER_W-1:0]     norm_er;
   logic                sr_add, mag_ge, same_sign, norm_done;
   logic [7:0]          s8_sum;
   logic                v8_sum;
   pack_t               pk;

   assign ea     = bus.in_a[EXP_MSB:EXP_LSB];
   assign eb     = bus.in_b[EXP_MSB:EXP_LSB];
   assign ediff  = (ea >= eb) ? (ea - eb) : (eb - ea);
   assign d_init = (ediff > 8'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : ediff[SHIFT_W-1:0];

   assign same_sign = (sign_a_q == sign_b_q);
   assign mag_ge    = (ma_q >= mb_q);
   assign r_add     = same_sign ? (ma_q + mb_q) : (mag_ge ? (ma_q - mb_q) : (mb_q - ma_q));
   assign sr_add    = (r_add == '0) ? 1'b0 : ((same_sign || mag_ge) ? sign_a_q : sign_b_q);

   // Signed overflow: operands effectively share a sign the wrapped sum does not.
   assign s8_sum = sub_q ? (a8_q - b8_q) : (a8_q + b8_q);
   assign v8_sum = sub_q ? ((a8_q[7] != b8_q[7]) && (s8_sum[7] != a8_q[7]))
                         : ((a8_q[7] == b8_q[7]) && (s8_sum[7] != a8_q[7]));

   assign pk = pack_result(sign_r_q, er_q, r_q);

   bf16_norm_step u_norm_step (
      .r_i    (r_q),
      .er_i   (er_q),
      .r_o    (norm_r),
      .er_o   (norm_er),
      .done_o (norm_done)
   );

   always_comb begin
      state_d      = state_q;
      ma_d         = ma_q;
      mb_d         = mb_q;
      r_d          = r_q;
      er_d         = er_q;
      d_d          = d_q;
      sign_a_d     = sign_a_q;
      sign_b_d     = sign_b_q;
      sign_r_d     = sign_r_q;
      shift_b_d    = shift_b_q;
      int8_d       = int8_q;
      sub_d        = sub_q;
      a8_d         = a8_q;
      b8_d         = b8_q;
      s8_d         = s8_q;
      v8_d         = v8_q;
      out_result_d = out_result_q;
      out_ovf_d    = out_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a8_d      = bus.in_a[7:0];
               b8_d      = bus.in_b[7:0];
               sub_d     = bus.in_sub;
               int8_d    = bus.in_int8;
               sign_a_d  = bus.in_a[SIGN_BIT];
               sign_b_d  = bus.in_b[SIGN_BIT] ^ bus.in_sub;
               ma_d      = {1'b0, (ea != 8'd0), bus.in_a[FRAC_MSB:FRAC_LSB], 1'b0};
               mb_d      = {1'b0, (eb != 8'd0), bus.in_b[FRAC_MSB:FRAC_LSB], 1'b0};
               shift_b_d = (ea >= eb);
               d_d       = d_init;
               er_d      = {1'b0, ((ea >= eb) ? ea : eb)} + ER_W'(1);
               state_d   = (bus.in_int8 || d_init == '0) ? ST_ADD : ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (shift_b_q) mb_d = mb_q >> 1;
            else           ma_d = ma_q >> 1;
            d_d = d_q - SHIFT_W'(1);
            if (d_q == SHIFT_W'(1)) state_d = ST_ADD;
         end
         ST_ADD: begin
            if (int8_q) begin
               s8_d = s8_sum;
               v8_d = v8_sum;
            end else begin
               r_d      = r_add;
               sign_r_d = sr_add;
            end
            state_d = ST_NORM;
         end
         ST_NORM: begin
            // INT8 passes straight through so both modes share the same exit path.
            if (int8_q) begin
               out_result_d = {{8{s8_q[7]}}, s8_q};
               out_ovf_d    = v8_q;
               state_d      = ST_DONE;
            end else if (norm_done) begin
               out_result_d = pk.result;
               out_ovf_d    = pk.ovf;
               state_d      = ST_DONE;
            end else begin
               r_d  = norm_r;
               er_d = norm_er;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ma_q         <= '0;
         mb_q         <= '0;
         r_q          <= '0;
         er_q         <= '0;
         d_q          <= '0;
         sign_a_q     <= 1'b0;
         sign_b_q     <= 1'b0;
         sign_r_q     <= 1'b0;
         shift_b_q    <= 1'b0;
         int8_q       <= 1'b0;
         sub_q        <= 1'b0;
         a8_q         <= '0;
         b8_q         <= '0;
         s8_q         <= '0;
         v8_q         <= 1'b0;
         out_result_q <= '0;
         out_ovf_q    <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ma_q         <= ma_d;
         mb_q         <= mb_d;
         r_q          <= r_d;
         er_q         <= er_d;
         d_q          <= d_d;
         sign_a_q     <= sign_a_d;
         sign_b_q     <= sign_b_d;
         sign_r_q     <= sign_r_d;
         shift_b_q    <= shift_b_d;
         int8_q       <= int8_d;
         sub_q        <= sub_d;
         a8_q         <= a8_d;
         b8_q         <= b8_d;
         s8_q         <= s8_d;
         v8_q         <= v8_d;
         out_result_q <= out_result_d;
         out_ovf_q    <= out_ovf_d;
         in_ready_q   <= (state_d == ST_IDLE);
         out_valid_q  <= (state_d == ST_DONE);
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_ovf    = out_ovf_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bf16_addsub_sequencer.sv
// Directed and randomized checks of bf16_addsub_sequencer against an arithmetic reference model.
module tb_bf16_addsub_sequencer;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   bf16_addsub_sequencer_if bus();

   bf16_addsub_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference: one-shot alignment, signed integer sum, count-based normalization.
   function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic int8,
                                  output logic [15:0] res, output logic ovf, output int lat);
      int ea, eb, ma, mb, d, va, vb, tot, r, er, k, s;
      logic sgn;
      logic [7:0] lo;
      logic [7:0] ee;
      logic [6:0] ff;
      if (int8) begin
         s   = int'($signed(a[7:0])) + (sub ? -int'($signed(b[7:0])) : int'($signed(b[7:0])));
         ovf = (s > 127) || (s < -128);
         lo  = 8'(s);
         res = {{8{lo[7]}}, lo};
         lat = 2;
         return;
      end
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      ma = ((ea != 0) ? 256 : 0) + int'(a[6:0]) * 2;
      mb = ((eb != 0) ? 256 : 0) + int'(b[6:0]) * 2;
      d  = (ea > eb) ? ea - eb : eb - ea;
      if (d > 10) d = 10;
      if (ea >= eb) mb = mb >> d;
      else          ma = ma >> d;
      va  = a[15] ? -ma : ma;
      vb  = (b[15] ^ sub) ? -mb : mb;
      tot = va + vb;
      r   = (tot < 0) ? -tot : tot;
      sgn = (tot < 0);
      er  = ((ea > eb) ? ea : eb) + 1;
      k   = 0;
      while (r != 0 && r < 512 && er != 0) begin
         r  = r * 2;
         er = er - 1;
         k++;
      end
      lat = d + k + 2;
      if (r == 0) begin
         res = 16'h0000;
         ovf = 1'b0;
      end else begin
         ovf = (er >= 255);
         ee  = 8'(er);
         ff  = 7'((r >> 2) & 127);
         res = {sgn, ee, ff};
`ifdef BF16_ADDSUB_SAT_EN
         if (ovf) res = {sgn, 8'hFF, 7'h00};
`endif
      end
   endfunction

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic int8,
                         input logic [15:0] e_res, input logic e_ovf, input int e_lat);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      bus.in_int8  = int8;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_a     = 16'h0000;
      bus.in_b     = 16'h0000;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " latency"}, 32'(n), 32'(e_lat));
      chk({tag, " result"}, 32'(bus.out_result), 32'(e_res));
      chk({tag, " ovf"}, 32'(bus.out_ovf), 32'(e_ovf));
      chk({tag, " in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
      chk({tag, " valid_dropped"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic run_rand(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic int8);
      logic [15:0] e_res;
      logic        e_ovf;
      int          e_lat;
      ref_op(a, b, sub, int8, e_res, e_ovf, e_lat);
      run_op(tag, a, b, sub, int8, e_res, e_ovf, e_lat);
   endtask

   initial begin
      logic [15:0] ovf_res;
      logic [15:0] ra, rb;
      int          ea_r, eb_r, n, seen;
      n_tests = 0;
      n_fail  = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = 16'h0000;
      bus.in_b      = 16'h0000;
      bus.in_sub    = 1'b0;
      bus.in_int8   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_result", 32'(bus.out_result), 32'd0);
      chk("rst out_ovf", 32'(bus.out_ovf), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("1p1", 16'h3F80, 16'h3F80, 1'b0, 1'b0, 16'h4000, 1'b0, 2);
      run_op("1p05", 16'h3F80, 16'h3F00, 1'b0, 1'b0, 16'h3FC0, 1'b0, 4);
      run_op("1m1", 16'h3F80, 16'h3F80, 1'b1, 1'b0, 16'h0000, 1'b0, 2);
      run_op("1p0", 16'h3F80, 16'h0000, 1'b0, 1'b0, 16'h3F80, 1'b0, 13);
      run_op("n1p05", 16'hBF80, 16'h3F00, 1'b0, 1'b0, 16'hBF00, 1'b0, 5);
      run_op("i8_100p50", 16'h0064, 16'h0032, 1'b0, 1'b1, 16'hFF96, 1'b1, 2);
      run_op("i8_5m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 2);
`ifdef BF16_ADDSUB_SAT_EN
      ovf_res = 16'h7F80;
`else
      ovf_res = 16'h7FFF;
`endif
      run_op("exp_ovf", 16'h7F7F, 16'h7F7F, 1'b0, 1'b0, ovf_res, 1'b1, 2);

      // Result held stable while the consumer stalls.
      bus.in_valid = 1'b1; bus.in_a = 16'h3F80; bus.in_b = 16'h3F80;
      bus.in_sub = 1'b0; bus.in_int8 = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("hold valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold result", 32'(bus.out_result), 32'h4000);
         chk("hold valid_stable", 32'(bus.out_valid), 32'd1);
         chk("hold in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("hold release", 32'(bus.in_ready), 32'd1);

      // Reset while aligning drops the operation.
      bus.in_valid = 1'b1; bus.in_a = 16'h3F80; bus.in_b = 16'h3D00;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midrst busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst busy_low", 32'(bus.busy), 32'd0);
      chk("midrst result", 32'(bus.out_result), 32'd0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      chk("midrst no_stale", 32'(seen), 32'd0);
      run_op("post_rst", 16'h3F80, 16'h3F00, 1'b0, 1'b0, 16'h3FC0, 1'b0, 4);

      for (int i = 0; i < 40; i++) begin
         ea_r = int'($urandom_range(1, 250));
         eb_r = ea_r + int'($urandom_range(0, 24)) - 12;
         if (eb_r < 0) eb_r = 0;
         if (eb_r > 254) eb_r = 254;
         if ($urandom_range(0, 7) == 0) eb_r = 0;
         ra = {1'($urandom_range(0, 1)), 8'(ea_r), 7'($urandom_range(0, 127))};
         rb = {1'($urandom_range(0, 1)), 8'(eb_r), 7'($urandom_range(0, 127))};
         if (i[0]) run_rand("rnd_f", rb, ra, 1'($urandom_range(0, 1)), 1'b0);
         else      run_rand("rnd_f", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         run_rand("rnd_i8", ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
